// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline hazard controller: instruction field
// positions, the NOP encoding and the controller state type.
package pipe_pkg;

  localparam logic [31:0] NOP_INSTR = 32'hF800_0000;

  localparam int OP_MSB = 31;
  localparam int OP_LSB = 27;
  localparam int RS_MSB = 26;
  localparam int RS_LSB = 22;
  localparam int RT_MSB = 21;
  localparam int RT_LSB = 17;

  localparam logic [4:0] NOP_OPCODE = NOP_INSTR[OP_MSB:OP_LSB];

  typedef enum logic [1:0] {
    RUN        = 2'd0,
    MUL_WAIT   = 2'd1,
    FETCH_WAIT = 2'd2
  } state_t;

  // True when the load in EX writes a register read by the IF/ID instruction.
  // rt is always compared, so immediate forms may stall needlessly.
  function automatic logic load_use_hit(input logic [31:0] instr,
                                        input logic        mem_read,
                                        input logic [4:0]  rd);
    logic [4:0] rs;
    logic [4:0] rt;
    rs = instr[RS_MSB:RS_LSB];
    rt = instr[RT_MSB:RT_LSB];
    return mem_read && (rd != 5'd0) && ((rd == rs) || (rd == rt));
  endfunction

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter used for the stall and flush statistics.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  // Count up on inc, stick at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
    end else if (inc && (count != {CNT_W{1'b1}})) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline. Control outputs are
// combinational from the current state and inputs; state, the multiply
// down-counter and the statistics counters are registered.
module pipeline_hazard_ctrl
  import pipe_pkg::*;
#(
  parameter int MUL_CYCLES = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [31:0]      id_instr,
  input  logic             ex_mem_read,
  input  logic [4:0]       ex_rd,
  input  logic             ex_mul_start,
  input  logic             branch_taken,
  input  logic             imem_ready,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             ifid_flush,
  output logic             idex_write,
  output logic             idex_flush,
  output logic [1:0]       busy_state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  // Wide enough to hold MUL_CYCLES-2, at least one bit.
  localparam int MC_W = (MUL_CYCLES > 2) ? $clog2(MUL_CYCLES) : 1;

  state_t          state_reg;
  state_t          state_next;
  logic [MC_W-1:0] mul_cnt_reg;
  logic [MC_W-1:0] mul_cnt_next;
  logic            stall_inc;
  logic            flush_inc;
  logic            load_use;
  logic            unused_bits;

  // A flushed NOP in IF/ID never requests a load-use stall.
  assign load_use = (id_instr[OP_MSB:OP_LSB] != NOP_OPCODE) &&
                    load_use_hit(id_instr, ex_mem_read, ex_rd);
  assign unused_bits = ^id_instr[RT_LSB-1:0];
  assign busy_state  = state_reg;

  // State and multiply down-counter; reset also aborts a multiply in flight.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg   <= RUN;
      mul_cnt_reg <= '0;
    end else begin
      state_reg   <= state_next;
      mul_cnt_reg <= mul_cnt_next;
    end
  end

  // Next-state and control outputs, prioritised branch > mul > load-use > fetch.
  always_comb begin
    pc_write     = 1'b1;
    ifid_write   = 1'b1;
    ifid_flush   = 1'b0;
    idex_write   = 1'b1;
    idex_flush   = 1'b0;
    state_next   = state_reg;
    mul_cnt_next = mul_cnt_reg;
    stall_inc    = 1'b0;
    flush_inc    = 1'b0;
    case (state_reg)
      RUN, FETCH_WAIT: begin
        state_next = RUN;
        if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
          flush_inc  = 1'b1;
        end else if (ex_mul_start) begin
          pc_write     = 1'b0;
          ifid_write   = 1'b0;
          idex_write   = 1'b0;
          mul_cnt_next = MC_W'(MUL_CYCLES - 2);
          // A two-cycle multiply only needs the start cycle frozen.
          state_next   = (MUL_CYCLES > 2) ? MUL_WAIT : RUN;
        end else if (load_use) begin
          // ifid_write=0 also holds an invalid fetch, so no separate flush.
          pc_write   = 1'b0;
          ifid_write = 1'b0;
          idex_flush = 1'b1;
          stall_inc  = 1'b1;
        end else if (!imem_ready) begin
          pc_write   = 1'b0;
          ifid_flush = 1'b1;
          stall_inc  = 1'b1;
          state_next = FETCH_WAIT;
        end
      end
      MUL_WAIT: begin
        pc_write   = 1'b0;
        ifid_write = 1'b0;
        idex_write = 1'b0;
        stall_inc  = 1'b1;
        // Counter holds remaining MUL_WAIT cycles; the one at 1 is the last.
        if (mul_cnt_reg <= MC_W'(1)) begin
          state_next = RUN;
        end else begin
          mul_cnt_next = mul_cnt_reg - 1'b1;
        end
      end
      default: begin
        state_next = RUN;
      end
    endcase
    if (rst) begin
      pc_write   = 1'b0;
      ifid_write = 1'b0;
      ifid_flush = 1'b1;
      idex_write = 1'b0;
      idex_flush = 1'b1;
      stall_inc  = 1'b0;
      flush_inc  = 1'b0;
    end
  end

  sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .count (stall_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .count (flush_cnt)
  );

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed bench for pipeline_hazard_ctrl. A second instance with 2-bit
// counters shares the stimulus and exercises counter saturation.
module tb_pipeline_hazard_ctrl;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] id_instr;
  logic        ex_mem_read;
  logic [4:0]  ex_rd;
  logic        ex_mul_start;
  logic        branch_taken;
  logic        imem_ready;

  logic        pc_write, ifid_write, ifid_flush, idex_write, idex_flush;
  logic [1:0]  busy_state;
  logic [15:0] stall_cnt, flush_cnt;

  logic        s_pc_write, s_ifid_write, s_ifid_flush, s_idex_write, s_idex_flush;
  logic [1:0]  s_busy_state;
  logic [1:0]  s_stall_cnt, s_flush_cnt;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_mul_start(ex_mul_start), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .pc_write(pc_write), .ifid_write(ifid_write),
    .ifid_flush(ifid_flush), .idex_write(idex_write), .idex_flush(idex_flush),
    .busy_state(busy_state), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipeline_hazard_ctrl #(.MUL_CYCLES(4), .CNT_W(2)) dut_small (
    .clk(clk), .rst(rst), .id_instr(id_instr), .ex_mem_read(ex_mem_read),
    .ex_rd(ex_rd), .ex_mul_start(ex_mul_start), .branch_taken(branch_taken),
    .imem_ready(imem_ready), .pc_write(s_pc_write), .ifid_write(s_ifid_write),
    .ifid_flush(s_ifid_flush), .idex_write(s_idex_write), .idex_flush(s_idex_flush),
    .busy_state(s_busy_state), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  // Advance one clock and settle just after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Build an instruction with the given opcode, rs and rt.
  function automatic logic [31:0] mk(input logic [4:0] op, input logic [4:0] rs,
                                     input logic [4:0] rt);
    return {op, rs, rt, 17'd0};
  endfunction

  initial begin
    rst = 1'b1; id_instr = 32'hF800_0000; ex_mem_read = 1'b0; ex_rd = 5'd0;
    ex_mul_start = 1'b0; branch_taken = 1'b0; imem_ready = 1'b1;

    // Reset held two cycles: outputs forced.
    tick(); tick();
    #3;
    check("rst_pc_write",   pc_write,   0);
    check("rst_ifid_write", ifid_write, 0);
    check("rst_ifid_flush", ifid_flush, 1);
    check("rst_idex_write", idex_write, 0);
    check("rst_idex_flush", idex_flush, 1);
    check("rst_stall_cnt",  stall_cnt,  0);
    check("rst_flush_cnt",  flush_cnt,  0);
    tick();
    rst = 1'b0; #3;
    check("run_pc_write",   pc_write,   1);
    check("run_ifid_write", ifid_write, 1);
    check("run_idex_write", idex_write, 1);
    check("run_ifid_flush", ifid_flush, 0);
    check("run_idex_flush", idex_flush, 0);
    check("run_busy",       busy_state, 0);
    tick();

    // Load-use on rs.
    id_instr = mk(5'd2, 5'd5, 5'd9); ex_mem_read = 1'b1; ex_rd = 5'd5; #3;
    check("lu_rs_pc_write",   pc_write,   0);
    check("lu_rs_ifid_write", ifid_write, 0);
    check("lu_rs_idex_flush", idex_flush, 1);
    check("lu_rs_ifid_flush", ifid_flush, 0);
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd0; #3;
    check("lu_bubble_pc_write",   pc_write,   1);
    check("lu_bubble_idex_flush", idex_flush, 0);
    check("lu_stall_cnt",         stall_cnt,  1);
    tick();

    // Load-use on rt.
    id_instr = mk(5'd2, 5'd3, 5'd7); ex_mem_read = 1'b1; ex_rd = 5'd7; #3;
    check("lu_rt_pc_write", pc_write, 0);
    tick();
    // Load to r0 never stalls.
    id_instr = mk(5'd2, 5'd0, 5'd0); ex_rd = 5'd0; #3;
    check("lu_r0_pc_write",   pc_write,   1);
    check("lu_r0_idex_flush", idex_flush, 0);
    check("lu_r0_stall_cnt",  stall_cnt,  2);
    tick();
    // Non-load producer does not stall.
    id_instr = mk(5'd2, 5'd5, 5'd1); ex_mem_read = 1'b0; ex_rd = 5'd5; #3;
    check("nolu_pc_write", pc_write, 1);
    tick();

    // Multiply, MUL_CYCLES=4: three frozen cycles, two of them in MUL_WAIT.
    ex_rd = 5'd0; ex_mul_start = 1'b1; #3;
    check("mul0_pc_write",   pc_write,   0);
    check("mul0_ifid_write", ifid_write, 0);
    check("mul0_idex_write", idex_write, 0);
    check("mul0_idex_flush", idex_flush, 0);
    check("mul0_busy",       busy_state, 0);
    tick();
    ex_mul_start = 1'b0; #3;
    check("mul1_busy",       busy_state, 1);
    check("mul1_pc_write",   pc_write,   0);
    check("mul1_idex_write", idex_write, 0);
    tick(); #3;
    check("mul2_busy",     busy_state, 1);
    check("mul2_pc_write", pc_write,   0);
    tick(); #3;
    check("mul3_busy",      busy_state,  0);
    check("mul3_pc_write",  pc_write,    1);
    check("mul_stall_cnt",  stall_cnt,   4);
    check("sat_stall_cnt",  s_stall_cnt, 3);
    tick();

    // Branch wins over a simultaneous load-use.
    id_instr = mk(5'd2, 5'd5, 5'd0); ex_mem_read = 1'b1; ex_rd = 5'd5;
    branch_taken = 1'b1; #3;
    check("br_ifid_flush", ifid_flush, 1);
    check("br_idex_flush", idex_flush, 1);
    check("br_pc_write",   pc_write,   1);
    tick();
    branch_taken = 1'b0; ex_mem_read = 1'b0; ex_rd = 5'd0; #3;
    check("br_flush_cnt", flush_cnt, 1);
    check("br_stall_cnt", stall_cnt, 4);
    tick();

    // Fetch wait for three cycles.
    imem_ready = 1'b0; #3;
    check("fw0_pc_write",   pc_write,   0);
    check("fw0_ifid_flush", ifid_flush, 1);
    check("fw0_idex_write", idex_write, 1);
    check("fw0_busy",       busy_state, 0);
    tick(); #3;
    check("fw1_busy",       busy_state, 2);
    check("fw1_ifid_flush", ifid_flush, 1);
    tick(); #3;
    check("fw2_busy",     busy_state, 2);
    check("fw2_pc_write", pc_write,   0);
    tick();
    imem_ready = 1'b1; #3;
    check("fw3_pc_write",   pc_write,   1);
    check("fw3_ifid_flush", ifid_flush, 0);
    check("fw3_ifid_write", ifid_write, 1);
    tick(); #3;
    check("fw_done_busy",   busy_state,  0);
    check("fw_stall_cnt",   stall_cnt,   7);
    check("fw_sat_stall",   s_stall_cnt, 3);
    tick();

    // Load-use together with an invalid fetch: one stall, no IF/ID flush.
    id_instr = mk(5'd2, 5'd5, 5'd0); ex_mem_read = 1'b1; ex_rd = 5'd5;
    imem_ready = 1'b0; #3;
    check("lufw_pc_write",   pc_write,   0);
    check("lufw_ifid_write", ifid_write, 0);
    check("lufw_ifid_flush", ifid_flush, 0);
    check("lufw_idex_flush", idex_flush, 1);
    tick();
    ex_mem_read = 1'b0; ex_rd = 5'd0; imem_ready = 1'b1; #3;
    check("lufw_stall_cnt", stall_cnt, 8);
    tick();

    // Reset while in MUL_WAIT.
    ex_mul_start = 1'b1; tick();
    ex_mul_start = 1'b0; #3;
    check("mrst_busy_pre", busy_state, 1);
    tick();
    rst = 1'b1; #3;
    check("mrst_ifid_flush", ifid_flush, 1);
    check("mrst_pc_write",   pc_write,   0);
    tick();
    rst = 1'b0; #3;
    check("mrst_busy",      busy_state, 0);
    check("mrst_stall_cnt", stall_cnt,  0);
    check("mrst_pc_write",  pc_write,   1);
    tick(); #3;
    check("mrst_busy_hold", busy_state, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
